// File: rtl/float_copro_ctrl.sv
// Sequencer in front of the FP coprocessor datapath: registers an LM32 user
// instruction, holds it for a per-opcode multicycle window, returns the result.
module float_copro_ctrl #(
   parameter int unsigned ADD_LAT = 2,
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned DIV_LAT = 6
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        user_valid,
   input  logic [10:0] user_opcode,
   input  logic [31:0] user_operand_0,
   input  logic [31:0] user_operand_1,
   output logic [31:0] user_result,
   output logic        user_complete,
   output logic        busy,
   output logic [10:0] dp_opcode,
   output logic [31:0] dp_op0,
   output logic [31:0] dp_op1,
   input  logic [31:0] dp_result,
   output logic        illegal_op,
   output logic        overrun,
   input  logic        clr_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DONE
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [10:0] r_dp_opcode;
   logic [31:0] r_dp_op0;
   logic [31:0] r_dp_op1;
   logic [31:0] r_result;
   logic        r_complete;
   logic        r_busy;
   logic        r_illegal;
   logic        r_overrun;

   logic [3:0]  w_lat;
   logic        w_dp_illegal;
   logic        w_last;
   logic        w_set_ill;
   logic        w_set_ovr;

   // Full 11-bit decode: anything other than 0..3 is illegal and takes one cycle
   always_comb begin
      w_lat = 4'd1;
      case (user_opcode)
         11'd0, 11'd1: w_lat = 4'(ADD_LAT);
         11'd2:        w_lat = 4'(MUL_LAT);
         11'd3:        w_lat = 4'(DIV_LAT);
         default:      w_lat = 4'd1;
      endcase
   end

   assign w_dp_illegal = (r_dp_opcode > 11'd3);
   assign w_last       = (r_state == ST_EXEC) && (r_cnt <= 4'd1);
   assign w_set_ill    = w_last && w_dp_illegal;
   assign w_set_ovr    = user_valid && (r_state != ST_IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_dp_opcode <= '0;
         r_dp_op0    <= '0;
         r_dp_op1    <= '0;
         r_result    <= '0;
         r_complete  <= 1'b0;
         r_busy      <= 1'b0;
         r_illegal   <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (user_valid) begin
                  r_dp_opcode <= user_opcode;
                  r_dp_op0    <= user_operand_0;
                  r_dp_op1    <= user_operand_1;
                  r_cnt       <= w_lat;
                  r_busy      <= 1'b1;
                  r_state     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_cnt <= r_cnt - 4'd1;
               if (w_last) begin
                  r_result   <= w_dp_illegal ? '0 : dp_result;
                  r_complete <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_complete <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_complete <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase

         // A set event outranks a simultaneous clear
         if (w_set_ill) begin
            r_illegal <= 1'b1;
         end else if (clr_err) begin
            r_illegal <= 1'b0;
         end

         if (w_set_ovr) begin
            r_overrun <= 1'b1;
         end else if (clr_err) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign user_result   = r_result;
   assign user_complete = r_complete;
   assign busy          = r_busy;
   assign dp_opcode     = r_dp_opcode;
   assign dp_op0        = r_dp_op0;
   assign dp_op1        = r_dp_op1;
   assign illegal_op    = r_illegal;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Scoreboard bench for float_copro_ctrl with a stub datapath and a cycle-level
// model of accept times, completion times and sticky flags.
module tb_float_copro_ctrl;

   localparam int ADD_L = 2;
   localparam int MUL_L = 3;
   localparam int DIV_L = 6;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        user_valid = 1'b0;
   logic [10:0] user_opcode = '0;
   logic [31:0] user_operand_0 = '0;
   logic [31:0] user_operand_1 = '0;
   logic [31:0] user_result;
   logic        user_complete;
   logic        busy;
   logic [10:0] dp_opcode;
   logic [31:0] dp_op0;
   logic [31:0] dp_op1;
   logic [31:0] dp_result;
   logic        illegal_op;
   logic        overrun;
   logic        clr_err = 1'b0;

   always #5 clk = ~clk;

   float_copro_ctrl #(
      .ADD_LAT(ADD_L),
      .MUL_LAT(MUL_L),
      .DIV_LAT(DIV_L)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .user_valid    (user_valid),
      .user_opcode   (user_opcode),
      .user_operand_0(user_operand_0),
      .user_operand_1(user_operand_1),
      .user_result   (user_result),
      .user_complete (user_complete),
      .busy          (busy),
      .dp_opcode     (dp_opcode),
      .dp_op0        (dp_op0),
      .dp_op1        (dp_op1),
      .dp_result     (dp_result),
      .illegal_op    (illegal_op),
      .overrun       (overrun),
      .clr_err       (clr_err)
   );

   // Stub datapath: exact IEEE answers for the directed vectors, integer mixes otherwise
   function automatic logic [31:0] dp_model(input logic [10:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      if (op == 11'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (op == 11'd1 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
      if (op == 11'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (op == 11'd3 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
      case (op)
         11'd0:   return a + b;
         11'd1:   return a - b;
         11'd2:   return a * b;
         11'd3:   return a ^ {b[15:0], b[31:16]};
         default: return 32'hBAD0BAD0;
      endcase
   endfunction

   always_comb dp_result = dp_model(dp_opcode, dp_op0, dp_op1);

   function automatic int lat_of(input logic [10:0] op);
      if (op == 11'd0 || op == 11'd1) return ADD_L;
      if (op == 11'd2) return MUL_L;
      if (op == 11'd3) return DIV_L;
      return 1;
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endfunction

   typedef struct {
      logic [31:0] res;
      int          cyc;
      logic        ill;
   } exp_t;

   exp_t        q[$];
   logic        in_rst = 1'b1;
   logic        m_live = 1'b0;
   int          m_accn = 0;
   int          m_lat = 0;
   int          m_free = 0;
   logic [10:0] m_op = '0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic        m_ill = 1'b0;
   logic        m_ovr = 1'b0;

   // Monitor: busy window, operand stability while busy, and completion scoreboard
   logic exp_busy;
   exp_t mon_e;
   always @(negedge clk) begin
      if (!in_rst) begin
         exp_busy = m_live && (cyc >= m_accn) && (cyc <= m_accn + m_lat);
         chk("busy", 32'(busy), 32'(exp_busy));
         if (exp_busy) begin
            chk("dp_opcode_hold", 32'(dp_opcode), 32'(m_op));
            chk("dp_op0_hold", dp_op0, m_a);
            chk("dp_op1_hold", dp_op1, m_b);
         end
         if (user_complete) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_complete at cycle %0d: got result %h, expected no completion",
                        cyc, user_result);
            end else begin
               mon_e = q.pop_front();
               chk("result", user_result, mon_e.res);
               chk("complete_cycle", 32'(cyc), 32'(mon_e.cyc));
               if (mon_e.ill) chk("illegal_at_complete", 32'(illegal_op), 32'd1);
            end
         end else if (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missing_complete at cycle %0d: got none, expected at cycle %0d",
                     cyc, mon_e.cyc);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         user_opcode    = 11'($urandom);
         user_operand_0 = $urandom;
         user_operand_1 = $urandom;
      end
   endtask

   task automatic send(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
      int   n;
      exp_t e;
      @(negedge clk);
      user_valid     = 1'b1;
      user_opcode    = op;
      user_operand_0 = a;
      user_operand_1 = b;
      n = cyc + 1;
      if (!m_live || n >= m_free) begin
         e.ill = (op > 11'd3);
         e.res = e.ill ? 32'h0 : exp;
         e.cyc = n + lat_of(op);
         q.push_back(e);
         m_accn = n;
         m_lat  = lat_of(op);
         m_free = n + m_lat + 2;
         m_op   = op;
         m_a    = a;
         m_b    = b;
         m_live = 1'b1;
         if (e.ill) m_ill = 1'b1;
      end else begin
         m_ovr = 1'b1;
      end
      @(negedge clk);
      user_valid     = 1'b0;
      user_opcode    = 11'($urandom);
      user_operand_0 = $urandom;
      user_operand_1 = $urandom;
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (q.size() == 0) break;
         idle(1);
      end
      if (q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout at cycle %0d: got %0d pending, expected 0", cyc, q.size());
         q.delete();
      end
      idle(2);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      m_ill = 1'b0;
      m_ovr = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_result"}, user_result, 32'h0);
      chk({tag, "_complete"}, 32'(user_complete), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_dp_opcode"}, 32'(dp_opcode), 32'h0);
      chk({tag, "_dp_op0"}, dp_op0, 32'h0);
      chk({tag, "_dp_op1"}, dp_op1, 32'h0);
      chk({tag, "_illegal"}, 32'(illegal_op), 32'h0);
      chk({tag, "_overrun"}, 32'(overrun), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog at cycle %0d: got no finish, expected completion of test", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [10:0] op;
      logic [31:0] a;
      logic [31:0] b;
      int          r;

      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_i  = 1'b0;
      in_rst = 1'b0;

      send(11'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
      drain();
      send(11'd1, 32'h40400000, 32'h3F800000, 32'h40000000);
      drain();
      send(11'd2, 32'h40000000, 32'h40400000, 32'h40C00000);
      drain();
      send(11'd3, 32'h40C00000, 32'h40000000, 32'h40400000);
      drain();

      send(11'h007, 32'h3F800000, 32'h3F800000, 32'h0);
      drain();
      chk("illegal_set", 32'(illegal_op), 32'd1);
      clr_pulse();
      chk("illegal_clr", 32'(illegal_op), 32'd0);

      send(11'h403, 32'h40C00000, 32'h40000000, 32'h0);
      drain();
      chk("illegal_403", 32'(illegal_op), 32'd1);
      clr_pulse();

      // clr_err lands on the same edge as the illegal completion
      send(11'h007, 32'h1, 32'h2, 32'h0);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("illegal_set_wins", 32'(illegal_op), 32'd1);
      drain();
      clr_pulse();
      chk("illegal_clr2", 32'(illegal_op), 32'd0);

      send(11'd3, 32'h40C00000, 32'h40000000, 32'h40400000);
      send(11'd0, 32'h11111111, 32'h22222222, 32'h33333333);
      while (cyc + 2 < m_free) idle(1);
      send(11'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
      drain();
      chk("overrun_set", 32'(overrun), 32'd1);
      chk("overrun_no_illegal", 32'(illegal_op), 32'd0);
      clr_pulse();
      chk("overrun_clr", 32'(overrun), 32'd0);

      send(11'd3, 32'h40C00000, 32'h40000000, 32'h40400000);
      idle(3);
      in_rst = 1'b1;
      rst_i  = 1'b1;
      q.delete();
      m_live = 1'b0;
      m_ill  = 1'b0;
      m_ovr  = 1'b0;
      @(negedge clk);
      check_zero("midreset");
      rst_i  = 1'b0;
      in_rst = 1'b0;
      idle(20);
      send(11'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
      drain();

      repeat (60) begin
         r = $urandom_range(0, 9);
         if (r < 8) op = 11'(r % 4);
         else if (r == 8) op = 11'h403;
         else op = 11'($urandom_range(4, 2047));
         a = $urandom;
         b = $urandom;
         send(op, a, b, dp_model(op, a, b));
         idle($urandom_range(0, 7));
      end
      drain();
      chk("final_illegal", 32'(illegal_op), 32'(m_ill));
      chk("final_overrun", 32'(overrun), 32'(m_ovr));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/float_copro_ctrl.md
Name: float_copro_ctrl

Overview:
- Sequencing stage directly upstream of the floating-point coprocessor datapath (add/sub/mul/div, opcodes 0..3) on the LM32 user-defined-instruction interface.
- Accepts an instruction request from the CPU and registers opcode and operands.
- Holds the registered values stable on the datapath inputs for a per-opcode multicycle window, then captures the datapath result and returns it with a one-cycle completion pulse.

Parameters:
- ADD_LAT, 2, cycles the datapath inputs are held for opcodes 0 (add) and 1 (sub); legal range 1..15
- MUL_LAT, 3, hold cycles for opcode 2 (mul); legal range 1..15
- DIV_LAT, 6, hold cycles for opcode 3 (div); legal range 1..15

Ports:
- clk_i  in  1  single clock; all state changes on the rising edge
- rst_i  in  1  synchronous, active-high reset
- user_valid  in  1  request strobe from the CPU, one cycle per instruction
- user_opcode  in  11  instruction opcode
- user_operand_0  in  32  operand A (IEEE-754 single)
- user_operand_1  in  32  operand B (IEEE-754 single)
- user_result  out  32  registered result; held until the next completion
- user_complete  out  1  one-cycle pulse; user_result is valid in the same cycle
- busy  out  1  high while a request is in flight
- dp_opcode  out  11  registered opcode driven to the datapath
- dp_op0  out  32  registered operand A driven to the datapath
- dp_op1  out  32  registered operand B driven to the datapath
- dp_result  in  32  combinational result returned by the datapath
- illegal_op  out  1  sticky flag: an opcode > 3 was accepted
- overrun  out  1  sticky flag: user_valid arrived while busy
- clr_err  in  1  clears illegal_op and overrun

Behaviour:
Reset (rst_i high at an edge):
- state=IDLE; user_result, dp_opcode, dp_op0, dp_op1 = 0; user_complete, busy, illegal_op, overrun = 0; counter = 0.
- Reset mid-operation aborts the request. No later user_complete is produced.

States: IDLE, EXEC, DONE.

IDLE:
- On user_valid=1 at edge N: register opcode/operands into dp_*; busy=1 from edge N.
- Load the counter with the opcode's latency:
  - 0, 1 → ADD_LAT
  - 2 → MUL_LAT
  - 3 → DIV_LAT
  - > 3 → 1
- Go to EXEC.

EXEC:
- Counter decrements each edge.
- At the edge where the counter reaches 0 (edge N+LAT):
  - user_result <= dp_result (or 0 for an illegal opcode, which also sets illegal_op);
  - user_complete <= 1;
  - go to DONE.
- dp_* must not change during EXEC.

DONE (one cycle):
- user_complete=1 and busy=1 during this cycle.
- At the next edge: user_complete <= 0, busy <= 0, go to IDLE.
- Completion therefore occupies the cycle following edge N+LAT. The earliest next accept is the edge after that (N+LAT+2).

Overrun:
- user_valid=1 in EXEC or DONE is ignored and sets overrun.
- Operands and result are unaffected.

Error flags:
- illegal_op and overrun hold until clr_err=1 or reset.
- If clr_err and a set event occur at the same edge, set wins.

Outputs and widths:
- user_result holds its value between completions; dp_* hold their last values in IDLE.
- All outputs are registered. Only the user_valid → state path and the dp_result → user_result capture are combinational inputs to flops.
- Opcode decode uses all 11 bits: e.g. 11'h403 is illegal, not div.
- Counter is 4 bits. LAT=1 means the complete pulse follows the edge directly after accept.

Test Plan:
- Reset, then user_valid with opcode 0, op0=0x3F800000, op1=0x40000000 → user_complete pulses exactly 2 cycles after the accept edge with user_result=0x40400000; busy is high 3 cycles.
- Opcode 1, 0x40400000 − 0x3F800000 → result 0x40000000, latency 2. Opcode 2, 0x40000000 × 0x40400000 → 0x40C00000, latency 3.
- Opcode 3, 0x40C00000 / 0x40000000 → 0x40400000 after 6 cycles; dp_op0/dp_op1 are checked stable every EXEC cycle while user_operand_* are randomized.
- Opcode 11'h007 → complete after 1 cycle with result 0x00000000, illegal_op=1. Then clr_err → 0. Then set and clear in the same cycle → flag stays 1.
- user_valid re-asserted during EXEC of a div → overrun=1, first result correct, no second complete. Back-to-back accept at N+LAT+2 succeeds.
- rst_i asserted mid-EXEC of a div → all outputs 0 next cycle, no complete pulse within 20 cycles; a subsequent add completes normally.
